// File: rtl/sysid_checker.sv
// ---------------------------------------------------------------------------
// sysid_checker
//
// Boot-time and periodic verifier for the system ID control slave. After
// reset, on a start request, or when the recheck interval elapses, it reads
// word 0 (system ID) and word 1 (build timestamp) over Avalon-MM, compares
// both against the expected values and reports the outcome.
//
// Ports
//   clock            single clock, rising edge
//   reset_n          asynchronous active-low reset
//   start            request a check (only honoured while idle)
//   avm_address      sysid word select (0 = ID, 1 = timestamp)
//   avm_read         read strobe
//   avm_waitrequest  interconnect stall
//   avm_readdata     read data, valid when read is accepted
//   busy             high whenever a check is in progress
//   done             one-cycle pulse at the end of each check
//   match / error    outcome of the last completed check
//   fault_code       00 none, 01 ID mismatch, 10 timestamp mismatch, 11 timeout
//   captured_id/ts   words read during the last completed check
//
// State table
//   state    | meaning
//   IDLE     | waiting for start or recheck expiry
//   RD_ID    | reading word 0 (system ID)
//   RD_TS    | reading word 1 (build timestamp)
//   CMP      | comparing captured words, publishing result
//   BACKOFF  | one quiet cycle before a retry; also the post-reset state,
//            | so the first edge after reset launches the boot check
// ---------------------------------------------------------------------------
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1363292375,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned RECHECK_CYCLES = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        match,
    output logic        error,
    output logic [1:0]  fault_code,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ID   = 3'd1,
        ST_RD_TS   = 3'd2,
        ST_CMP     = 3'd3,
        ST_BACKOFF = 3'd4
    } state_t;

    localparam logic [1:0]  FAULT_NONE = 2'b00;
    localparam logic [1:0]  FAULT_ID   = 2'b01;
    localparam logic [1:0]  FAULT_TS   = 2'b10;
    localparam logic [1:0]  FAULT_TMO  = 2'b11;

    localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RETRY_MAX  = 4'(MAX_RETRIES);
    localparam logic [31:0] RECHK_LAST = 32'(RECHECK_CYCLES - 1);
    localparam bit          RECHK_EN   = (RECHECK_CYCLES != 0);

    state_t      r_state;
    state_t      w_state_nxt;

    logic [15:0] r_wait;
    logic [3:0]  r_retry;
    logic [31:0] r_recheck;
    logic [31:0] r_id_sh;
    logic [31:0] r_ts_sh;

    logic        r_avm_read;
    logic        r_avm_addr;
    logic        r_busy;
    logic        r_done;
    logic        r_match;
    logic        r_error;
    logic [1:0]  r_fault;
    logic [31:0] r_cap_id;
    logic [31:0] r_cap_ts;

    logic        w_finish;
    logic        w_retry_inc;
    logic [1:0]  w_fault_nxt;
    logic        w_tmo;
    logic        w_rechk_hit;
    logic        w_in_read;

    // The stall that makes the count reach TIMEOUT_CYCLES is the abort edge.
    assign w_tmo       = avm_waitrequest && (r_wait == WAIT_LAST);
    assign w_rechk_hit = RECHK_EN && (r_recheck == RECHK_LAST);
    assign w_in_read   = (r_state == ST_RD_ID) || (r_state == ST_RD_TS);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_BACKOFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_finish    = 1'b0;
        w_retry_inc = 1'b0;
        w_fault_nxt = r_fault;
        case (r_state)
            ST_IDLE: begin
                if (start || w_rechk_hit) begin
                    w_state_nxt = ST_RD_ID;
                end
            end
            ST_RD_ID, ST_RD_TS: begin
                if (!avm_waitrequest) begin
                    w_state_nxt = (r_state == ST_RD_ID) ? ST_RD_TS : ST_CMP;
                end else if (w_tmo) begin
                    if (r_retry < RETRY_MAX) begin
                        w_retry_inc = 1'b1;
                        w_state_nxt = ST_BACKOFF;
                    end else begin
                        w_finish    = 1'b1;
                        w_fault_nxt = FAULT_TMO;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_CMP: begin
                w_finish    = 1'b1;
                w_state_nxt = ST_IDLE;
                if (r_id_sh != EXPECTED_ID) begin
                    w_fault_nxt = FAULT_ID;
                end else if (r_ts_sh != EXPECTED_TS) begin
                    w_fault_nxt = FAULT_TS;
                end else begin
                    w_fault_nxt = FAULT_NONE;
                end
            end
            ST_BACKOFF: begin
                w_state_nxt = ST_RD_ID;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Counters and capture shadows. Words land in the shadows as they are
    // accepted; the visible copies only change when a check completes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wait    <= '0;
            r_retry   <= '0;
            r_recheck <= '0;
            r_id_sh   <= '0;
            r_ts_sh   <= '0;
        end else begin
            if (w_in_read && (w_state_nxt == r_state)) begin
                r_wait <= r_wait + 16'd1;
            end else begin
                r_wait <= '0;
            end

            if (w_finish) begin
                r_retry <= '0;
            end else if (w_retry_inc) begin
                r_retry <= r_retry + 4'd1;
            end

            if (RECHK_EN && (r_state == ST_IDLE) && (w_state_nxt == ST_IDLE)) begin
                r_recheck <= r_recheck + 32'd1;
            end else begin
                r_recheck <= '0;
            end

            if ((r_state == ST_RD_ID) && !avm_waitrequest) begin
                r_id_sh <= avm_readdata;
            end
            if ((r_state == ST_RD_TS) && !avm_waitrequest) begin
                r_ts_sh <= avm_readdata;
            end
        end
    end

    // Registered outputs are computed from the next state so the bus
    // strobes line up with the state they belong to.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_avm_read <= 1'b0;
            r_avm_addr <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_match    <= 1'b0;
            r_error    <= 1'b0;
            r_fault    <= FAULT_NONE;
            r_cap_id   <= '0;
            r_cap_ts   <= '0;
        end else begin
            r_avm_read <= (w_state_nxt == ST_RD_ID) || (w_state_nxt == ST_RD_TS);
            r_avm_addr <= (w_state_nxt == ST_RD_TS);
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_done     <= w_finish;
            if (w_finish) begin
                r_fault  <= w_fault_nxt;
                r_match  <= (w_fault_nxt == FAULT_NONE);
                r_error  <= (w_fault_nxt != FAULT_NONE);
                r_cap_id <= r_id_sh;
                r_cap_ts <= r_ts_sh;
            end
        end
    end

    assign avm_read    = r_avm_read;
    assign avm_address = r_avm_addr;
    assign busy        = r_busy;
    assign done        = r_done;
    assign match       = r_match;
    assign error       = r_error;
    assign fault_code  = r_fault;
    assign captured_id = r_cap_id;
    assign captured_ts = r_cap_ts;

endmodule

// File: tb/tb_sysid_checker.sv
// ---------------------------------------------------------------------------
// tb_sysid_checker
//
// Drives sysid_checker through boot, mismatch, timeout, stall, recheck and
// mid-read reset scenarios plus a randomized series of checks. A small
// Avalon slave serves configurable words with a per-read stall plan; the
// expected outcome of every check is derived from that plan.
// ---------------------------------------------------------------------------
module tb_sysid_checker;

    localparam int          TMO     = 4;
    localparam int          RETRIES = 1;
    localparam int          RECHK   = 10;
    localparam logic [31:0] EXP_ID  = 32'd0;
    localparam logic [31:0] EXP_TS  = 32'd1363292375;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = 32'd0;
    logic        busy;
    logic        done;
    logic        match;
    logic        error;
    logic [1:0]  fault_code;
    logic [31:0] captured_id;
    logic [31:0] captured_ts;

    sysid_checker #(
        .EXPECTED_ID   (EXP_ID),
        .EXPECTED_TS   (EXP_TS),
        .TIMEOUT_CYCLES(TMO),
        .MAX_RETRIES   (RETRIES),
        .RECHECK_CYCLES(RECHK)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata   (avm_readdata),
        .busy           (busy),
        .done           (done),
        .match          (match),
        .error          (error),
        .fault_code     (fault_code),
        .captured_id    (captured_id),
        .captured_ts    (captured_ts)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // slave configuration and stall plan (one entry per read, in order)
    logic [31:0] sl_id = 32'd0;
    logic [31:0] sl_ts = 32'd0;
    int          plan[$];

    // monitor counts
    int mon_n0 = 0;
    int mon_n1 = 0;
    int mon_lo = 0;
    int mon_done = 0;

    bit in_read = 1'b0;
    int remain = 0;

    always @(negedge clock) begin
        if (avm_read) begin
            if (!in_read) begin
                in_read = 1'b1;
                remain = (plan.size() > 0) ? plan.pop_front() : 0;
            end
            if (remain > 0) begin
                avm_waitrequest = 1'b1;
                avm_readdata    = $urandom;
                remain--;
            end else begin
                avm_waitrequest = 1'b0;
                avm_readdata    = avm_address ? sl_ts : sl_id;
                in_read         = 1'b0;
                if (avm_address) mon_n1++;
                else             mon_n0++;
            end
        end else begin
            in_read         = 1'b0;
            avm_waitrequest = 1'($urandom_range(0, 1));
            avm_readdata    = $urandom;
        end
        if (busy && !avm_read) mon_lo++;
        if (done) mon_done++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_cap_id = 32'd0;
    logic [31:0] m_cap_ts = 32'd0;

    task automatic step;
        @(negedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outcome of one check from the stall plan: each read stalls s cycles
    // and completes in s+1 cycles, or aborts after TMO stalls; an abort
    // costs one quiet cycle and restarts from word 0 while retries remain.
    task automatic predict(input int st[$], output int cyc_done, output logic [1:0] f,
                           output int n0, output int n1, output int nbo,
                           output bit gid, output bit gts);
        int cur;
        int tries;
        int s;
        bit aborted;
        cur = 1; tries = 0; n0 = 0; n1 = 0; nbo = 0;
        gid = 1'b0; gts = 1'b0; f = 2'b00; cyc_done = 0;
        while (1) begin
            aborted = 1'b0;
            for (int w = 0; w < 2 && !aborted; w++) begin
                s = (st.size() > 0) ? st.pop_front() : 0;
                if (s >= TMO) begin
                    cur += TMO;
                    aborted = 1'b1;
                end else begin
                    cur += s + 1;
                    if (w == 0) begin n0++; gid = 1'b1; end
                    else        begin n1++; gts = 1'b1; end
                end
            end
            if (!aborted) begin
                cyc_done = cur + 1;
                f = (sl_id != EXP_ID) ? 2'b01 : (sl_ts != EXP_TS) ? 2'b10 : 2'b00;
                return;
            end
            if (tries >= RETRIES) begin
                cyc_done = cur;
                f = 2'b11;
                return;
            end
            tries++;
            nbo++;
            cur += 1;
        end
    endtask

    // Entered either at the step of a done cycle (first idle cycle) or,
    // when boot=1, with reset held low. start_at: idle cycle on which to
    // pulse start, -1 to let the recheck timer launch the check.
    task automatic run_check(input string tag, input int start_at, input bit boot);
        int idle, e0, cnt, b0, b1, blo, bdone;
        int exp_cyc, n0, n1, nbo;
        logic [1:0] f;
        bit gid, gts;
        int q[$];
        q = plan;
        predict(q, exp_cyc, f, n0, n1, nbo, gid, gts);
        b0 = mon_n0; b1 = mon_n1; blo = mon_lo; bdone = mon_done;
        if (boot) begin
            reset_n = 1'b1;
            step;
            chk({tag, "_boot_busy"}, 64'(busy), 64'd1);
        end else begin
            idle = 0;
            while (!busy && idle < 40) begin
                start = (idle == start_at);
                step;
                idle++;
            end
            chk({tag, "_idle_cycles"}, 64'(idle), 64'((start_at < 0) ? RECHK : start_at + 1));
        end
        e0 = cyc;
        cnt = 0;
        while (!done && cnt < 300) begin
            start = 1'($urandom_range(0, 1));
            step;
            cnt++;
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 64'(done), 64'd1);
        chk({tag, "_done_cycle"}, 64'(cyc - e0 + 1), 64'(exp_cyc));
        chk({tag, "_busy_low"}, 64'(busy), 64'd0);
        if (gid) m_cap_id = sl_id;
        if (gts) m_cap_ts = sl_ts;
        chk({tag, "_fault"}, 64'(fault_code), 64'(f));
        chk({tag, "_match"}, 64'(match), 64'(f == 2'b00));
        chk({tag, "_error"}, 64'(error), 64'(f != 2'b00));
        chk({tag, "_cap_id"}, 64'(captured_id), 64'(m_cap_id));
        chk({tag, "_cap_ts"}, 64'(captured_ts), 64'(m_cap_ts));
        chk({tag, "_reads0"}, 64'(mon_n0 - b0), 64'(n0));
        chk({tag, "_reads1"}, 64'(mon_n1 - b1), 64'(n1));
        chk({tag, "_quiet"}, 64'(mon_lo - blo), 64'(nbo + ((f != 2'b11) ? 1 : 0)));
        chk({tag, "_done_count"}, 64'(mon_done - bdone), 64'd1);
    endtask

    task automatic set_slave(input logic [31:0] id, input logic [31:0] ts);
        sl_id = id;
        sl_ts = ts;
        plan.delete();
    endtask

    logic [31:0] rid;
    logic [31:0] rts;
    int          guard;

    initial begin
        #1 reset_n = 1'b0;
        set_slave(EXP_ID, EXP_TS);
        step;
        chk("reset_outputs", 64'(|{busy, done, match, error, fault_code, captured_id,
                                    captured_ts, avm_read, avm_address}), 64'd0);
        step;
        step;

        // boot check with a zero-wait, correct slave
        run_check("boot", -1, 1'b1);

        // ID mismatch: no retry, one read per word
        set_slave(32'h0000_0005, EXP_TS);
        run_check("id_mismatch", 0, 1'b0);

        // permanent stall: two aborted attempts, then timeout
        set_slave(EXP_ID, EXP_TS);
        plan.push_back(1000);
        plan.push_back(1000);
        run_check("timeout", 2, 1'b0);

        // three stalls on the timestamp read only
        set_slave(EXP_ID, EXP_TS);
        plan.push_back(0);
        plan.push_back(3);
        run_check("ts_stall3", 1, 1'b0);

        // timestamp mismatch
        set_slave(EXP_ID, 32'hDEAD_BEEF);
        run_check("ts_mismatch", 3, 1'b0);

        // start coinciding with recheck expiry, then a plain recheck
        set_slave(EXP_ID, EXP_TS);
        run_check("rechk_start", RECHK - 1, 1'b0);
        run_check("rechk_auto", -1, 1'b0);

        // randomized checks
        for (int i = 0; i < 16; i++) begin
            rid = ($urandom_range(0, 2) != 0) ? EXP_ID : $urandom;
            rts = ($urandom_range(0, 2) != 0) ? EXP_TS : $urandom;
            set_slave(rid, rts);
            for (int k = 0; k < 4; k++) begin
                plan.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6))
                                                           : int'($urandom_range(0, 2)));
            end
            run_check($sformatf("rand%0d", i), int'($urandom_range(0, RECHK)) - 1, 1'b0);
        end

        // reset while the timestamp read is stalled
        set_slave(EXP_ID, EXP_TS);
        plan.push_back(0);
        plan.push_back(3);
        start = 1'b1;
        step;
        start = 1'b0;
        guard = 0;
        while (!(avm_read && avm_address) && guard < 20) begin
            step;
            guard++;
        end
        chk("mid_rd_ts_reached", 64'(avm_read && avm_address), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_reset_read_low", 64'(avm_read), 64'd0);
        chk("mid_reset_outputs", 64'(|{busy, done, match, error, fault_code, captured_id,
                                       captured_ts, avm_read, avm_address}), 64'd0);
        m_cap_id = 32'd0;
        m_cap_ts = 32'd0;
        step;
        step;
        set_slave(EXP_ID, EXP_TS);
        run_check("reboot", -1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
